// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder
//  Description : Registered, lane-parallel half adder. WIDTH independent
//                1-bit lanes each produce sum = a ^ b and carry = a & b one
//                clock after a valid input. A saturating counter tracks the
//                number of valid cycles in which any lane generated a carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module half_adder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] sum_out,
   output logic [WIDTH-1:0] carry_out,
   output logic             valid_out,
   output logic             any_carry_out,
   output logic [CNT_W-1:0] carry_cnt_out
);

   // Counter ceiling (all ones) and unit increment at the counter width.
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;
   logic             w_any_carry;
   logic             w_cnt_inc;

   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_carry;
   logic             r_valid;
   logic             r_any_carry;
   logic [CNT_W-1:0] r_cnt;

   // One independent half adder per lane; nothing crosses lane boundaries.
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_lane
         assign w_sum[i]   = a_in[i] ^ b_in[i];
         assign w_carry[i] = a_in[i] & b_in[i];
      end
   endgenerate

   assign w_any_carry = |w_carry;

   // Count only valid carry cycles, and stop at the ceiling instead of wrapping.
   assign w_cnt_inc = valid_in & w_any_carry & (r_cnt != c_cnt_max);

   // Result registers: load on valid, hold on idle; valid strobe follows valid_in.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum       <= '0;
         r_carry     <= '0;
         r_any_carry <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         r_valid <= valid_in;
         if (valid_in) begin
            r_sum       <= w_sum;
            r_carry     <= w_carry;
            r_any_carry <= w_any_carry;
         end
      end
   end

   // Saturating carry-event counter, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_cnt <= r_cnt + c_cnt_one;
      end
   end

   assign sum_out       = r_sum;
   assign carry_out     = r_carry;
   assign valid_out     = r_valid;
   assign any_carry_out = r_any_carry;
   assign carry_cnt_out = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_half_adder
//  Description : Directed scoreboard bench for half_adder (4 lanes, 2-bit
//                carry counter). Stimulus queues the hand-computed expected
//                output state together with the cycle it is due; the monitor
//                compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_half_adder;
   localparam int WIDTH = 4;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_in;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] sum_out;
   logic [WIDTH-1:0] carry_out;
   logic             valid_out;
   logic             any_carry_out;
   logic [CNT_W-1:0] carry_cnt_out;

   typedef struct {
      string       tag;
      int unsigned due;
      logic        v;
      logic [3:0]  s;
      logic [3:0]  c;
      logic        any;
      logic [1:0]  cnt;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc      = 0;
   int          checks   = 0;
   int          failures = 0;
   bit          done     = 1'b0;

   half_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_in      (valid_in),
      .a_in          (a_in),
      .b_in          (b_in),
      .sum_out       (sum_out),
      .carry_out     (carry_out),
      .valid_out     (valid_out),
      .any_carry_out (any_carry_out),
      .carry_cnt_out (carry_cnt_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input string tag, input int unsigned due, input logic v,
                       input logic [3:0] s, input logic [3:0] c, input logic any,
                       input logic [1:0] cnt);
      exp_t e;
      e.tag = tag; e.due = due; e.v = v; e.s = s; e.c = c; e.any = any; e.cnt = cnt;
      q.push_back(e);
   endtask

   // One valid input; its result is due on the cycle after the sampling edge.
   task automatic send(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] s, input logic [3:0] c, input logic any,
                       input logic [1:0] cnt);
      @(posedge clk); #1;
      rst = 1'b0; valid_in = 1'b1; a_in = a; b_in = b;
      push(tag, cyc + 1, 1'b1, s, c, any, cnt);
   endtask

   // Two reset edges with a valid 1111/1111 input that must be discarded.
   task automatic do_reset(input string tag);
      @(posedge clk); #1;
      rst = 1'b1; valid_in = 1'b1; a_in = 4'hF; b_in = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; valid_in = 1'b0; a_in = 4'h0; b_in = 4'h0;
      push(tag, cyc, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0);
   endtask

   // Idle cycles with zero operands: outputs must hold, valid_out must drop.
   task automatic idle(input string tag, input int n, input logic [3:0] s,
                       input logic [3:0] c, input logic any, input logic [1:0] cnt);
      @(posedge clk); #1;
      valid_in = 1'b0; a_in = 4'h0; b_in = 4'h0;
      for (int k = 0; k < n; k++) push(tag, cyc + 1 + k, 1'b0, s, c, any, cnt);
      repeat (n) @(posedge clk);
   endtask

   task automatic cmp(input string tag, input string field, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s cycle=%0d actual=%0h required=%0h", tag, field, cyc, act, exp);
      end
   endtask

   // Monitor: compare whatever is due this cycle; a stray valid_out is an error.
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due == cyc) begin
         exp_t e;
         e = q.pop_front();
         cmp(e.tag, "valid_out",     32'(valid_out),     32'(e.v));
         cmp(e.tag, "sum_out",       32'(sum_out),       32'(e.s));
         cmp(e.tag, "carry_out",     32'(carry_out),     32'(e.c));
         cmp(e.tag, "any_carry_out", 32'(any_carry_out), 32'(e.any));
         cmp(e.tag, "carry_cnt_out", 32'(carry_cnt_out), 32'(e.cnt));
      end else if (valid_out === 1'b1) begin
         cmp("unexpected", "valid_out", 32'(valid_out), 32'd0);
      end
      if (done) begin
         cmp("drain", "pending", 32'(q.size()), 32'd0);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "timeout");
   end

   // Toggle stream: b toggles every cycle, a every two cycles, all lanes alike.
   logic [3:0] ta [10] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
   logic [3:0] tb_ [10] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
   logic [3:0] ts [10] = '{4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF};
   logic [3:0] tc [10] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
   logic       tany[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [1:0] tcnt[10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};

   initial begin
      rst = 1'b1; valid_in = 1'b0; a_in = 4'h0; b_in = 4'h0;

      do_reset("reset");

      // Exhaustive truth table on lane 0, other lanes idle at zero.
      send("exh_00", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
      send("exh_01", 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0);
      send("exh_10", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0);
      send("exh_11", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd1);

      do_reset("reset_toggle");
      for (int k = 0; k < 10; k++)
         send($sformatf("toggle_%0d", k), ta[k], tb_[k], ts[k], tc[k], tany[k], tcnt[k]);

      do_reset("reset_hold");
      send("hold_src", 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 2'd1);
      idle("hold", 3, 4'h0, 4'hF, 1'b1, 2'd1);

      do_reset("reset_lanes");
      send("lanes_a", 4'b1100, 4'b1010, 4'b0110, 4'b1000, 1'b1, 2'd1);
      send("lanes_b", 4'b0101, 4'b0011, 4'b0110, 4'b0001, 1'b1, 2'd2);
      send("lanes_c", 4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd2);
      send("lanes_d", 4'b0110, 4'b0110, 4'b0000, 4'b0110, 1'b1, 2'd3);

      do_reset("reset_sat");
      send("sat_1", 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 2'd1);
      send("sat_2", 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 2'd2);
      send("sat_3", 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 2'd3);
      send("sat_4", 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 2'd3);
      send("sat_5", 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 2'd3);
      idle("sat_hold", 2, 4'h0, 4'hF, 1'b1, 2'd3);
      do_reset("sat_reset");

      repeat (3) @(posedge clk);
      #1 done = 1'b1;
   end
endmodule
`default_nettype wire
